// File: rtl/mac_layer_seq.sv
// Serial neural-layer evaluator: one 8x8 MAC steps through N_OUT neurons of N_IN inputs and stores ReLU results.
// Optional per-neuron bias enabled with macro MAC_SEQ_BIAS_EN.
module mac_layer_seq #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        in_wr_en,
    input  logic [$clog2(N_IN)-1:0]                     in_wr_addr,
    input  logic signed [7:0]                           in_wr_data,
    input  logic                                        w_wr_en,
    input  logic [$clog2(N_IN*N_OUT)-1:0]               w_wr_addr,
    input  logic signed [7:0]                           w_wr_data,
`ifdef MAC_SEQ_BIAS_EN
    input  logic                                        b_wr_en,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] b_wr_addr,
    input  logic signed [7:0]                           b_wr_data,
`endif
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_rd_addr,
    output logic signed [15:0]                          out_rd_data,
    output logic                                        busy,
    output logic                                        done
);

    localparam int IAW = $clog2(N_IN);
    localparam int WAW = $clog2(N_IN * N_OUT);
    localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IAW-1:0] I_LAST = IAW'(N_IN - 1);
    localparam logic [OAW-1:0] J_LAST = OAW'(N_OUT - 1);
    localparam logic [WAW-1:0] W_LAST = WAW'(N_IN * N_OUT - 1);

    function automatic logic signed [15:0] relu(input logic signed [15:0] a);
        if (a[15]) begin
            relu = 16'sd0;
        end else begin
            relu = a;
        end
    endfunction

    logic [2:0]          state_q, state_d;
    logic signed [15:0]  acc_q,   acc_d;
    logic [IAW-1:0]      i_q,     i_d;
    logic [OAW-1:0]      j_q,     j_d;
    logic signed [7:0]   x_q   [N_IN];
    logic signed [7:0]   x_d   [N_IN];
    logic signed [7:0]   w_q   [N_IN*N_OUT];
    logic signed [7:0]   w_d   [N_IN*N_OUT];
    logic signed [15:0]  out_q [N_OUT];
    logic signed [15:0]  out_d [N_OUT];
`ifdef MAC_SEQ_BIAS_EN
    logic signed [7:0]   bias_q [N_OUT];
    logic signed [7:0]   bias_d [N_OUT];
`endif

    logic               busy_s;
    logic [WAW-1:0]     w_idx_s;
    logic signed [15:0] x_ext_s;
    logic signed [15:0] w_ext_s;
    logic signed [15:0] prod_s;
    logic signed [15:0] clear_val_s;

    assign busy_s = (state_q != S_IDLE);
    assign busy   = busy_s;
    assign done   = (state_q == S_DONE);

    // Operand fetch and full-precision signed product for the current (neuron, input) pair.
    always_comb begin
        w_idx_s = WAW'(int'(j_q) * N_IN + int'(i_q));
        x_ext_s = {{8{x_q[i_q][7]}}, x_q[i_q]};
        w_ext_s = {{8{w_q[w_idx_s][7]}}, w_q[w_idx_s]};
        prod_s  = 16'(x_ext_s * w_ext_s);
`ifdef MAC_SEQ_BIAS_EN
        clear_val_s = {{8{bias_q[j_q][7]}}, bias_q[j_q]};
`else
        clear_val_s = 16'sd0;
`endif
    end

    // Sequencer next-state plus storage writes (host writes only land while idle).
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        x_d     = x_q;
        w_d     = w_q;
        out_d   = out_q;
`ifdef MAC_SEQ_BIAS_EN
        bias_d  = bias_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                acc_d   = clear_val_s;
                i_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + prod_s;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = S_STORE;
                end else begin
                    i_d     = i_q + IAW'(1);
                    state_d = S_MAC;
                end
            end
            S_STORE: begin
                out_d[j_q] = relu(acc_q);
                if (j_q == J_LAST) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + OAW'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                j_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                acc_d   = 16'sd0;
                i_d     = '0;
                j_d     = '0;
                state_d = S_IDLE;
            end
        endcase

        if (!busy_s && in_wr_en && (in_wr_addr <= I_LAST)) begin
            x_d[in_wr_addr] = in_wr_data;
        end else begin
            x_d[0] = x_q[0];
        end
        if (!busy_s && w_wr_en && (w_wr_addr <= W_LAST)) begin
            w_d[w_wr_addr] = w_wr_data;
        end else begin
            w_d[0] = w_q[0];
        end
`ifdef MAC_SEQ_BIAS_EN
        if (!busy_s && b_wr_en && (b_wr_addr <= J_LAST)) begin
            bias_d[b_wr_addr] = b_wr_data;
        end else begin
            bias_d[0] = bias_q[0];
        end
`endif
    end

    // State and storage registers; rst clears everything including the buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 16'sd0;
            i_q     <= '0;
            j_q     <= '0;
            for (int k = 0; k < N_IN; k++)         x_q[k]   <= 8'sd0;
            for (int k = 0; k < N_IN * N_OUT; k++) w_q[k]   <= 8'sd0;
            for (int k = 0; k < N_OUT; k++)        out_q[k] <= 16'sd0;
`ifdef MAC_SEQ_BIAS_EN
            for (int k = 0; k < N_OUT; k++)        bias_q[k] <= 8'sd0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            x_q     <= x_d;
            w_q     <= w_d;
            out_q   <= out_d;
`ifdef MAC_SEQ_BIAS_EN
            bias_q  <= bias_d;
`endif
        end
    end

    // Result buffer read port; unpopulated addresses read zero.
    always_comb begin
        if (out_rd_addr <= J_LAST) begin
            out_rd_data = out_q[out_rd_addr];
        end else begin
            out_rd_data = 16'sd0;
        end
    end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Directed self-checking bench for mac_layer_seq at default parameters (N_IN=4, N_OUT=4).
// Build with MAC_SEQ_BIAS_EN defined to exercise the bias variant.
module tb_mac_layer_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_wr_en = 1'b0;
    logic [1:0]         in_wr_addr = 2'd0;
    logic signed [7:0]  in_wr_data = 8'sd0;
    logic               w_wr_en = 1'b0;
    logic [3:0]         w_wr_addr = 4'd0;
    logic signed [7:0]  w_wr_data = 8'sd0;
`ifdef MAC_SEQ_BIAS_EN
    logic               b_wr_en = 1'b0;
    logic [1:0]         b_wr_addr = 2'd0;
    logic signed [7:0]  b_wr_data = 8'sd0;
`endif
    logic [1:0]         out_rd_addr = 2'd0;
    logic signed [15:0] out_rd_data;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_bad = 0;

    mac_layer_seq #(.N_IN(4), .N_OUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_wr_en    (in_wr_en),
        .in_wr_addr  (in_wr_addr),
        .in_wr_data  (in_wr_data),
        .w_wr_en     (w_wr_en),
        .w_wr_addr   (w_wr_addr),
        .w_wr_data   (w_wr_data),
`ifdef MAC_SEQ_BIAS_EN
        .b_wr_en     (b_wr_en),
        .b_wr_addr   (b_wr_addr),
        .b_wr_data   (b_wr_data),
`endif
        .out_rd_addr (out_rd_addr),
        .out_rd_data (out_rd_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_x(input int a, input int d);
        in_wr_en = 1'b1; in_wr_addr = 2'(a); in_wr_data = 8'(d);
        tick();
        in_wr_en = 1'b0;
    endtask

    task automatic wr_w(input int a, input int d);
        w_wr_en = 1'b1; w_wr_addr = 4'(a); w_wr_data = 8'(d);
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic load_ref();
        int xv[4];
        int wv[16];
        xv = '{1, 2, 3, 4};
        wv = '{1, 1, 1, 1, -1, -1, -1, -1, 2, 0, 0, 0, 0, 0, 0, 5};
        for (int k = 0; k < 4; k++)  wr_x(k, xv[k]);
        for (int k = 0; k < 16; k++) wr_w(k, wv[k]);
`ifdef MAC_SEQ_BIAS_EN
        b_wr_en = 1'b1; b_wr_addr = 2'd0; b_wr_data = -8'sd5;
        tick();
        b_wr_addr = 2'd1; b_wr_data = -8'sd20;
        tick();
        b_wr_en = 1'b0;
`endif
    endtask

    task automatic chk_outs(input string tag, input int e0, input int e1, input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            out_rd_addr = 2'(k);
            #1;
            chk($sformatf("%s_out%0d", tag, k), int'(out_rd_data), ev[k]);
        end
    endtask

    // Start a run and check busy/done every cycle; optionally poke start and a weight write mid-run.
    task automatic run_layer(input string tag, input bit inject);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), int'(busy), 1);
            chk($sformatf("%s_done%0d", tag, k), int'(done), (k == 24) ? 1 : 0);
            if (inject && (k == 5)) begin
                start = 1'b1; w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 8'sd99;
            end else begin
                start = 1'b0; w_wr_en = 1'b0;
            end
            tick();
        end
        chk($sformatf("%s_busy_end", tag), int'(busy), 0);
        chk($sformatf("%s_done_end", tag), int'(done), 0);
    endtask

    initial begin
        int done_seen;
        int e0_ref;
        int e0_wrap;
`ifdef MAC_SEQ_BIAS_EN
        e0_ref  = 5;
        e0_wrap = 507;
`else
        e0_ref  = 10;
        e0_wrap = 512;
`endif

        #1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_outs("rst", 0, 0, 0, 0);

        load_ref();
        run_layer("ref", 1'b0);
        chk_outs("ref", e0_ref, 0, 2, 20);

        run_layer("inj", 1'b1);
        chk_outs("inj", e0_ref, 0, 2, 20);

        for (int k = 0; k < 4; k++) wr_x(k, 127);
        for (int k = 0; k < 4; k++) wr_w(k, -128);
        run_layer("wrap", 1'b0);
        chk_outs("wrap", e0_wrap, 0, 254, 635);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort_pre_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk_outs("abort", 0, 0, 0, 0);
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);

        load_ref();
        run_layer("rerun", 1'b0);
        chk_outs("rerun", e0_ref, 0, 2, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_layer_seq.md
MAC_LAYER_SEQ -- requirements
Module: mac_layer_seq

Interface
REQ-001 Parameter N_IN, default 4: inputs per neuron (dot-product length), 2..16.
REQ-002 Parameter N_OUT, default 4: neurons per layer, evaluated serially on one internal MAC, 1..16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  launch layer evaluation; sampled only in IDLE.
REQ-006 in_wr_en  in  1 / in_wr_addr  in  clog2(N_IN) / in_wr_data  in  8 signed: write x[in_wr_addr].
REQ-007 w_wr_en  in  1 / w_wr_addr  in  clog2(N_IN*N_OUT) / w_wr_data  in  8 signed: write weight; neuron j input i lives at j*N_IN+i.
REQ-008 out_rd_addr  in  clog2(N_OUT) / out_rd_data  out  16 signed: combinational read of result buffer.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  single-cycle pulse, high only in DONE.

Function
REQ-011 FSM states IDLE, CLEAR, MAC, STORE, DONE.
REQ-012 IDLE->CLEAR when start=1; else stay.
REQ-013 CLEAR (1 cycle): acc<=0, input index i<=0; next MAC.
REQ-014 MAC (exactly N_IN cycles): acc<=acc+x[i]*w[j*N_IN+i], i<=i+1; after i=N_IN-1 go STORE.
REQ-015 Product: full 16-bit signed 8x8; accumulation 16-bit two's-complement, wraps silently on overflow.
REQ-016 STORE (1 cycle): out[j]<=relu(acc) (acc bit15=1 -> 0, else acc); if j=N_OUT-1 go DONE, else j<=j+1, go CLEAR.
REQ-017 DONE (1 cycle): done=1, j<=0; next IDLE unconditionally; start ignored in DONE.
REQ-018 Latency: done high exactly N_OUT*(N_IN+2) rising edges after the edge sampling start (24 at defaults); busy high for that many cycles plus DONE cycle.
REQ-019 in_wr_en and w_wr_en honoured only while busy=0; ignored (no write) while busy=1.
REQ-020 start while busy=1 is ignored; no queuing.
REQ-021 out buffer entries not yet re-stored keep prior-run values during a run; out_rd_data reflects a STORE on the next cycle.
REQ-022 Writes and start in the same IDLE cycle: write takes effect, run uses the new value only if it is consumed after that edge (all MAC reads occur after CLEAR, so it does).

Reset
REQ-023 rst=1 forces IDLE, busy=0, done=0, acc=0, i=0, j=0 on next edge, overriding all other inputs, including mid-run.
REQ-024 rst clears x, weight and out storage to 0; out_rd_data reads 0 for every address after reset.
REQ-025 Run aborted by rst produces no done pulse.

Configuration
REQ-026 Macro MAC_SEQ_BIAS_EN defined: adds ports b_wr_en in 1, b_wr_addr in clog2(N_OUT), b_wr_data in 8 signed (same busy gating as REQ-019), per-neuron bias storage cleared by rst; CLEAR loads acc with sign-extended bias[j] instead of 0.
REQ-027 Macro undefined: bias ports and storage absent; CLEAR loads 0; behaviour otherwise identical, including latency.

Verification
REQ-028 x={1,2,3,4}; w n0={1,1,1,1}, n1={-1,-1,-1,-1}, n2={2,0,0,0}, n3={0,0,0,5}; start -> out={10,0,2,20}.
REQ-029 x={127,127,127,127}, n0 w={-128,-128,-128,-128}: sum -65024 wraps to +512 -> out[0]=512.
REQ-030 start at edge T -> busy high from T+1 through T+25 inclusive, done high only in the cycle following edge T+24, busy=0 after T+25.
REQ-031 During run: start pulse and w_wr_en to address 0 with value 99 -> no restart, done timing unchanged, w[0] unchanged after run.
REQ-032 rst asserted 10 cycles into run -> next cycle busy=0, done=0, all out reads 0, no done pulse; fresh start then completes in 24 cycles.
REQ-033 MAC_SEQ_BIAS_EN defined: bias0=-5, bias1=-20 with REQ-028 data -> out[0]=5, out[1]=0.
